axi4_sram_slave: RTL and testbench
==================================

Name: axi4_sram_slave

Overview:
- AXI4 memory responder: the slave end of the 64-bit memory port that the noop core drives as master.
- Serves core AXI traffic from an on-chip synchronous SRAM, so the core runs without the PS DDR path (bring-up, simulation, boot ROM/RAM).
- Handles one transaction at a time. Write and read channels are arbitrated round-robin.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 8, AXI ID width.
- DATA_WIDTH, 64, fixed. Bytes per beat = 8.
- MEM_DEPTH_LOG2, 12, log2 of the number of 64-bit words (default 32 KiB).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  AW payload
- s_axi_awvalid  in  1 ; s_axi_awready  out  1
- s_axi_wdata/wstrb/wlast  in  64/8/1  W payload
- s_axi_wvalid  in  1 ; s_axi_wready  out  1
- s_axi_bid/bresp  out  ID_WIDTH/2  B payload
- s_axi_bvalid  out  1 ; s_axi_bready  in  1
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  AR payload
- s_axi_arvalid  in  1 ; s_axi_arready  out  1
- s_axi_rid/rdata/rresp/rlast  out  ID_WIDTH/64/2/1  R payload
- s_axi_rvalid  out  1 ; s_axi_rready  in  1

Behaviour:
- States: IDLE, W_DATA, B_RESP, R_FETCH, R_DATA.
- Reset values:
  - state IDLE; priority bit = write.
  - All valid/ready outputs 0; bresp/rresp 0; rdata 0; rlast 0; bid/rid 0.
  - SRAM contents are not reset.
- IDLE grant:
  - grant_w = awvalid & (!arvalid | prio==W); grant_r = arvalid & !grant_w.
  - awready = IDLE & grant_w; arready = IDLE & grant_r (combinational from state and valids).
- AW handshake: latch id, addr, len, size, burst; clear beat counter and error flags; go W_DATA.
- W_DATA:
  - wready = 1.
  - Each handshake writes the bytes selected by wstrb to word (addr-BASE_ADDR)>>3, only if the beat is legal and in range.
  - Address then advances.
  - On beat == len, go B_RESP, whether or not wlast is set.
- B_RESP:
  - bvalid = 1 with bid = latched id; held until bready.
  - On handshake: go IDLE, prio = read.
- AR handshake: latch id, addr, len, size, burst; go R_FETCH.
- R_FETCH: one cycle for the SRAM read; go R_DATA.
- R_DATA:
  - rvalid = 1; rid = latched id; rlast = (beat == len).
  - rdata and rresp are registered and stay stable while rready = 0.
  - On handshake: if last, go IDLE and set prio = write; else advance address and go R_FETCH.
- Latency and throughput:
  - AR handshake at cycle t gives first rvalid at t+2.
  - Back-to-back beats are spaced 2 cycles.
  - After the last W beat, bvalid appears on the next cycle.
- Address advance:
  - FIXED (00): address unchanged.
  - INCR (01): addr += 1<<size, modulo 2^ADDR_WIDTH.
- Legality:
  - size > 3, or burst WRAP/reserved (1x): whole burst is SLVERR (2'b10).
  - Illegal bursts make no SRAM write, and reads return 0.
- Range check:
  - A beat is out of range when addr < BASE_ADDR or addr >= BASE_ADDR + 8<<MEM_DEPTH_LOG2.
  - Out-of-range beat gives DECERR (2'b11), write dropped, rdata 0.
- Response codes:
  - Read: per-beat rresp.
  - Write: bresp is the sticky worst over the burst, precedence DECERR > SLVERR > OKAY.
  - wlast asserted before the final beat, or missing on it: bresp at least SLVERR, but exactly len+1 beats are still consumed.
- Narrow transfers: wstrb is applied as given; reads always return the full 64-bit word.
- Reset mid-burst:
  - Next cycle is IDLE with outputs at reset values.
  - The pending burst is abandoned with no response; already-written beats remain in the SRAM.
- No outstanding transactions: awready/arready stay 0 outside IDLE.

Test Plan:
- Single-beat write: awaddr 0x8000_0010, wdata 0x1122334455667788, wstrb 0xFF, bready = 1 -> bvalid one cycle after the W beat, bresp 0, bid = awid. Then AR to the same address -> rdata 0x1122334455667788, rlast = 1, rvalid 2 cycles after the AR handshake.
- INCR 4-beat write: awlen 3, size 3, base 0x8000_0100, data 0..3, beat 2 wstrb 0x0F over prior 0xFFFF_FFFF_FFFF_FFFF. INCR read back -> 0, 1, 0xFFFF_FFFF_0000_0002, 3; rlast on beat 4 only.
- Arbitration: awvalid and arvalid together in the first IDLE after reset -> write served first, then read. Next simultaneous pair -> read served first.
- Error responses:
  - Read at 0x0000_0000, arlen 1 -> two beats, rresp 3, rdata 0.
  - Write burst 2'b10 -> bresp 2, SRAM unchanged.
  - wlast on beat 1 of a 3-beat write -> bresp 2, and 3 beats accepted.
- Backpressure: hold rready = 0 for 5 cycles mid-burst -> rdata, rresp, rlast stable, and no beat skipped. Hold bready = 0 -> bvalid held, and awready stays 0.
- Reset mid W_DATA after 2 of 4 beats -> awready/arready reachable the next cycle, no bvalid ever, beats 0–1 present in the SRAM and beats 2–3 unchanged.

Source files
------------

// File: rtl/axi4_sram_slave.sv
// AXI4 slave that serves one burst at a time from an on-chip synchronous SRAM.
// The AW and AR channels share the SRAM and are granted round-robin from IDLE.
module axi4_sram_slave #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           ID_WIDTH       = 8,
  parameter int unsigned           DATA_WIDTH     = 64,
  parameter int unsigned           MEM_DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  // state   | meaning
  // IDLE    | no burst in flight, round-robin grant of AW vs AR
  // W_DATA  | accepting len+1 write beats
  // B_RESP  | holding the write response until bready
  // R_FETCH | SRAM read cycle for the current read beat
  // R_DATA  | presenting the registered read beat until rready

  typedef enum logic [2:0] {IDLE, W_DATA, B_RESP, R_FETCH, R_DATA} state_t;

  localparam int unsigned MEM_BYTES_LOG2 = MEM_DEPTH_LOG2 + 3;
  localparam int unsigned STRB_W         = DATA_WIDTH / 8;

  state_t                  state_q, state_d;
  logic                    prio_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [7:0]              beat_q;
  logic [1:0]              bresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;

  logic [DATA_WIDTH-1:0]   mem [2**MEM_DEPTH_LOG2];

  logic                    grant_w, grant_r;
  logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                    last_beat, illegal, in_range, beat_ok;
  logic [ADDR_WIDTH-1:0]   offset, addr_step, addr_next;
  logic [MEM_DEPTH_LOG2-1:0] word_idx;
  logic [1:0]              beat_code, w_code;

  // prio_q = 0 favours the write channel, 1 favours the read channel
  assign grant_w = s_axi_awvalid & (~s_axi_arvalid | ~prio_q);
  assign grant_r = s_axi_arvalid & ~grant_w;

  assign s_axi_awready = (state_q == IDLE) & grant_w;
  assign s_axi_arready = (state_q == IDLE) & grant_r;
  assign s_axi_wready  = (state_q == W_DATA);
  assign s_axi_bvalid  = (state_q == B_RESP);
  assign s_axi_rvalid  = (state_q == R_DATA);
  assign s_axi_bid     = id_q;
  assign s_axi_rid     = id_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rlast   = s_axi_rvalid & last_beat;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign b_hs  = s_axi_bvalid & s_axi_bready;
  assign r_hs  = s_axi_rvalid & s_axi_rready;

  assign last_beat = (beat_q == len_q);
  assign illegal   = (size_q > 3'd3) | burst_q[1];
  assign offset    = addr_q - BASE_ADDR;
  assign in_range  = (addr_q >= BASE_ADDR) && ((offset >> MEM_BYTES_LOG2) == '0);
  assign word_idx  = offset[MEM_BYTES_LOG2-1:3];
  assign beat_ok   = ~illegal & in_range;
  assign addr_step = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size_q;
  assign addr_next = (burst_q == 2'b01) ? addr_q + addr_step : addr_q;

  always_comb begin
    beat_code = 2'b00;
    if (illegal)
      beat_code = 2'b10;
    else if (!in_range)
      beat_code = 2'b11;
    w_code = beat_code;
    // a misplaced wlast downgrades an otherwise clean beat to SLVERR
    if ((s_axi_wlast != last_beat) && (beat_code == 2'b00))
      w_code = 2'b10;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs)
          state_d = W_DATA;
        else if (ar_hs)
          state_d = R_FETCH;
      end
      W_DATA:  if (w_hs && last_beat) state_d = B_RESP;
      B_RESP:  if (b_hs) state_d = IDLE;
      R_FETCH: state_d = R_DATA;
      R_DATA:  if (r_hs) state_d = last_beat ? IDLE : R_FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      bresp_q <= 2'b00;
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        id_q    <= s_axi_awid;
        addr_q  <= s_axi_awaddr;
        len_q   <= s_axi_awlen;
        size_q  <= s_axi_awsize;
        burst_q <= s_axi_awburst;
        beat_q  <= '0;
        bresp_q <= 2'b00;
      end
      if (ar_hs) begin
        id_q    <= s_axi_arid;
        addr_q  <= s_axi_araddr;
        len_q   <= s_axi_arlen;
        size_q  <= s_axi_arsize;
        burst_q <= s_axi_arburst;
        beat_q  <= '0;
      end
      if (w_hs) begin
        // codes are ordered so the numerically larger one is the worse one
        if (w_code > bresp_q)
          bresp_q <= w_code;
        if (!last_beat)
          beat_q <= beat_q + 8'd1;
        addr_q <= addr_next;
      end
      if (b_hs)
        prio_q <= 1'b1;
      if (state_q == R_FETCH) begin
        rdata_q <= beat_ok ? mem[word_idx] : '0;
        rresp_q <= beat_code;
      end
      if (r_hs) begin
        if (last_beat) begin
          prio_q <= 1'b0;
        end else begin
          beat_q <= beat_q + 8'd1;
          addr_q <= addr_next;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_hs && beat_ok) begin
      for (int b = 0; b < STRB_W; b++)
        if (s_axi_wstrb[b])
          mem[word_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed plus randomized bench for axi4_sram_slave against a byte-addressed
// behavioural memory model built from the AXI burst rules.
module tb_axi4_sram_slave;
  localparam int          DL   = 12;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  awid = '0, arid = '0, awlen = '0, arlen = '0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [7:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;

  always #5 clock = ~clock;

  axi4_sram_slave dut (
    .clock(clock), .reset(reset),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  int checks = 0;
  int errors = 0;

  bit [63:0]   mem_m [bit [31:0]];
  bit [31:0]   mw_addr;
  bit [7:0]    mw_len;
  bit [2:0]    mw_size;
  bit [1:0]    mw_burst;
  bit [1:0]    mw_err;
  int          mw_beat;
  bit [63:0]   wd [256];
  bit [7:0]    ws [256];
  logic [63:0] rd_data [256];
  logic [1:0]  last_bresp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_in_range(bit [31:0] a);
    return (a >= BASE) && (a < BASE + (32'd8 << DL));
  endfunction

  function automatic bit m_legal(bit [2:0] s, bit [1:0] b);
    return (s <= 3'd3) && (b < 2'd2);
  endfunction

  function automatic bit [1:0] m_code(bit [31:0] a, bit [2:0] s, bit [1:0] b);
    if (!m_legal(s, b)) return 2'b10;
    if (!m_in_range(a)) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [63:0] m_read(bit [31:0] a, bit [2:0] s, bit [1:0] b);
    bit [31:0] wa;
    wa = a & ~32'h7;
    if (!m_legal(s, b) || !m_in_range(a)) return 64'h0;
    if (!mem_m.exists(wa)) return 'x;
    return mem_m[wa];
  endfunction

  function automatic bit [31:0] m_advance(bit [31:0] a, bit [2:0] s, bit [1:0] b);
    return (b == 2'b01) ? a + (32'd1 << s) : a;
  endfunction

  task automatic aw_send(input bit [7:0] id, input bit [31:0] a, input bit [7:0] len,
                         input bit [2:0] s, input bit [1:0] b);
    int n;
    mw_addr = a; mw_len = len; mw_size = s; mw_burst = b; mw_err = 2'b00; mw_beat = 0;
    awid = id; awaddr = a; awlen = len; awsize = s; awburst = b; awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clock); #1; n++; end
    chk("awready", awready, 1'b1);
    @(negedge clock);
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input bit [63:0] d, input bit [7:0] st, input bit last);
    int n;
    bit [31:0] wa;
    bit [63:0] w;
    bit [1:0]  code;
    wdata = d; wstrb = st; wlast = last; wvalid = 1'b1;
    #1;
    n = 0;
    while (!wready && n < 20) begin @(negedge clock); #1; n++; end
    chk("wready", wready, 1'b1);
    wa = mw_addr & ~32'h7;
    if (m_legal(mw_size, mw_burst) && m_in_range(mw_addr)) begin
      w = mem_m.exists(wa) ? mem_m[wa] : 64'h0;
      for (int b = 0; b < 8; b++)
        if (st[b]) w[8*b +: 8] = d[8*b +: 8];
      mem_m[wa] = w;
    end
    code = m_code(mw_addr, mw_size, mw_burst);
    if ((last != (mw_beat == int'(mw_len))) && code < 2'b10) code = 2'b10;
    if (code > mw_err) mw_err = code;
    mw_addr = m_advance(mw_addr, mw_size, mw_burst);
    mw_beat++;
    @(negedge clock);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_take(input bit [7:0] id, input int bstall);
    #1;
    chk("b_latency", bvalid, 1'b1);
    for (int i = 0; i < bstall; i++) begin
      awvalid = 1'b1;
      #1;
      chk("awready_in_bresp", awready, 1'b0);
      chk("bvalid_held", bvalid, 1'b1);
      @(negedge clock);
    end
    awvalid = 1'b0;
    bready = 1'b1;
    #1;
    chk("bvalid", bvalid, 1'b1);
    chk("bresp", bresp, mw_err);
    chk("bid", bid, id);
    last_bresp = bresp;
    @(negedge clock);
    bready = 1'b0;
    #1;
    chk("bvalid_drop", bvalid, 1'b0);
  endtask

  task automatic do_write(input bit [7:0] id, input bit [31:0] a, input bit [7:0] len,
                          input bit [2:0] s, input bit [1:0] b, input int wlast_at,
                          input int bstall);
    aw_send(id, a, len, s, b);
    for (int i = 0; i <= int'(len); i++)
      w_beat(wd[i], ws[i], (wlast_at < 0) ? (i == int'(len)) : (i == wlast_at));
    b_take(id, bstall);
  endtask

  task automatic do_read(input bit [7:0] id, input bit [31:0] a, input bit [7:0] len,
                         input bit [2:0] s, input bit [1:0] b, input int stall_beat,
                         input int stall_n);
    int n;
    logic [63:0] exp_d;
    arid = id; araddr = a; arlen = len; arsize = s; arburst = b; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clock); #1; n++; end
    chk("arready", arready, 1'b1);
    @(negedge clock);
    arvalid = 1'b0;
    for (int beat = 0; beat <= int'(len); beat++) begin
      n = 1;
      #1;
      while (!rvalid && n < 20) begin @(negedge clock); #1; n++; end
      chk("r_spacing", n, 2);
      exp_d = m_read(a, s, b);
      if (beat == stall_beat) begin
        for (int k = 0; k < stall_n; k++) begin
          @(negedge clock);
          #1;
          chk("r_stall_valid", rvalid, 1'b1);
          chk("r_stall_data", rdata, exp_d);
          chk("r_stall_resp", rresp, m_code(a, s, b));
          chk("r_stall_last", rlast, beat == int'(len));
        end
      end
      rready = 1'b1;
      chk("rid", rid, id);
      chk("rdata", rdata, exp_d);
      chk("rresp", rresp, m_code(a, s, b));
      chk("rlast", rlast, beat == int'(len));
      rd_data[beat] = rdata;
      @(negedge clock);
      rready = 1'b0;
      a = m_advance(a, s, b);
    end
    #1;
    chk("rvalid_drop", rvalid, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_awready", awready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_bresp", {bresp, rresp}, 4'h0);
    chk("rst_ids", {bid, rid}, 16'h0);

    // first simultaneous request after reset goes to the write channel
    @(negedge clock);
    awvalid = 1'b1; arvalid = 1'b1;
    #1;
    chk("arb1_awready", awready, 1'b1);
    chk("arb1_arready", arready, 1'b0);
    #1;
    awvalid = 1'b0; arvalid = 1'b0;
    @(negedge clock);

    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    do_write(8'h5A, 32'h8000_0010, 8'd0, 3'd3, 2'b01, -1, 0);
    chk("single_bresp", last_bresp, 2'b00);

    // write was served last, so the read channel wins the next tie
    @(negedge clock);
    awvalid = 1'b1; arvalid = 1'b1;
    #1;
    chk("arb2_awready", awready, 1'b0);
    chk("arb2_arready", arready, 1'b1);
    #1;
    awvalid = 1'b0; arvalid = 1'b0;
    @(negedge clock);

    do_read(8'hA5, 32'h8000_0010, 8'd0, 3'd3, 2'b01, -1, 0);
    chk("single_rdata", rd_data[0], 64'h1122334455667788);

    for (int i = 0; i < 4; i++) begin wd[i] = '1; ws[i] = 8'hFF; end
    do_write(8'h01, 32'h8000_0100, 8'd3, 3'd3, 2'b01, -1, 0);
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i); ws[i] = 8'hFF; end
    ws[2] = 8'h0F;
    do_write(8'h02, 32'h8000_0100, 8'd3, 3'd3, 2'b01, -1, 0);
    do_read(8'h03, 32'h8000_0100, 8'd3, 3'd3, 2'b01, 1, 5);
    chk("incr_b0", rd_data[0], 64'h0);
    chk("incr_b1", rd_data[1], 64'h1);
    chk("incr_b2", rd_data[2], 64'hFFFF_FFFF_0000_0002);
    chk("incr_b3", rd_data[3], 64'h3);

    do_read(8'h04, 32'h0000_0000, 8'd1, 3'd3, 2'b01, -1, 0);
    chk("decerr_rdata", rd_data[1], 64'h0);

    wd[0] = 64'hCAFE_F00D_DEAD_BEEF; ws[0] = 8'hFF;
    do_write(8'h05, 32'h8000_0300, 8'd0, 3'd3, 2'b01, -1, 0);
    wd[0] = 64'h0; wd[1] = 64'h0;
    ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(8'h06, 32'h8000_0300, 8'd1, 3'd3, 2'b10, -1, 3);
    chk("wrap_bresp", last_bresp, 2'b10);
    do_read(8'h07, 32'h8000_0300, 8'd0, 3'd3, 2'b01, -1, 0);
    chk("wrap_unchanged", rd_data[0], 64'hCAFE_F00D_DEAD_BEEF);
    do_read(8'h08, 32'h8000_0300, 8'd0, 3'd3, 2'b10, -1, 0);

    for (int i = 0; i < 3; i++) begin wd[i] = 64'(i + 100); ws[i] = 8'hFF; end
    do_write(8'h09, 32'h8000_0400, 8'd2, 3'd3, 2'b01, 1, 0);
    chk("early_wlast_bresp", last_bresp, 2'b10);

    // reset after 2 of 4 beats: beats 0-1 stick, beats 2-3 keep old contents
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0A0_0000_0000_0000 | 64'(i); ws[i] = 8'hFF; end
    do_write(8'h0A, 32'h8000_0200, 8'd3, 3'd3, 2'b01, -1, 0);
    aw_send(8'h0B, 32'h8000_0200, 8'd3, 3'd3, 2'b01);
    w_beat(64'h5555_0000_0000_0000, 8'hFF, 1'b0);
    w_beat(64'h5555_0000_0000_0001, 8'hFF, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    awvalid = 1'b1;
    #1;
    chk("mid_rst_awready", awready, 1'b1);
    chk("mid_rst_wready", wready, 1'b0);
    awvalid = 1'b0; arvalid = 1'b1;
    #1;
    chk("mid_rst_arready", arready, 1'b1);
    arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      chk("mid_rst_no_bvalid", bvalid, 1'b0);
    end
    do_read(8'h0C, 32'h8000_0200, 8'd3, 3'd3, 2'b01, -1, 0);
    chk("mid_rst_b1", rd_data[1], 64'h5555_0000_0000_0001);
    chk("mid_rst_b2", rd_data[2], 64'hA0A0_0000_0000_0002);

    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      do_write(8'(blk), 32'h8000_1000 + 32'(blk * 128), 8'd15, 3'd3, 2'b01, -1, 0);
    end
    for (int it = 0; it < 24; it++) begin
      bit [31:0] a;
      bit [7:0]  len;
      bit [2:0]  s;
      bit [1:0]  b;
      a   = 32'h8000_1000 + 32'($urandom_range(0, 55) * 8);
      len = 8'($urandom_range(0, 7));
      s   = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3;
      b   = 2'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= int'(len); i++) begin
          wd[i] = {$urandom, $urandom};
          ws[i] = 8'($urandom);
        end
        do_write(8'($urandom), a, len, s, b, -1, $urandom_range(0, 2));
      end else begin
        do_read(8'($urandom), a, len, s, b, $urandom_range(0, 7), $urandom_range(0, 3));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
